// File: rtl/gdp_pkg.sv
// Shared constants for the gdp microprogrammed sequencer: code points, field
// positions, FSM encoding and the default (summation) microprogram.
package gdp_pkg;

  localparam int UINST_W = 22;

  localparam logic [1:0] SEQ_NEXT = 2'b00;
  localparam logic [1:0] SEQ_JUMP = 2'b01;
  localparam logic [1:0] SEQ_BRZ  = 2'b10;
  localparam logic [1:0] SEQ_HALT = 2'b11;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_AND   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_NOT   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;
  localparam logic [2:0] ALU_INC   = 3'b110;
  localparam logic [2:0] ALU_DEC   = 3'b111;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_SHL  = 2'b01;
  localparam logic [1:0] SH_SHR  = 2'b10;
  localparam logic [1:0] SH_ROTR = 2'b11;

  localparam int F_SEQ_HI = 21;
  localparam int F_SEQ_LO = 20;
  localparam int F_TGT_HI = 19;
  localparam int F_TGT_LO = 16;
  localparam int F_IE     = 15;
  localparam int F_WE     = 14;
  localparam int F_WA_HI  = 13;
  localparam int F_WA_LO  = 12;
  localparam int F_RAE    = 11;
  localparam int F_RAA_HI = 10;
  localparam int F_RAA_LO = 9;
  localparam int F_RBE    = 8;
  localparam int F_RBA_HI = 7;
  localparam int F_RBA_LO = 6;
  localparam int F_ALU_HI = 5;
  localparam int F_ALU_LO = 3;
  localparam int F_SH_HI  = 2;
  localparam int F_SH_LO  = 1;
  localparam int F_OE     = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Field order: seq, target, ie, we, wa, rae, raa, rbe, rba, alu, sh, oe.
  localparam logic [UINST_W-1:0] DEFAULT_PROG [16] = '{
    {SEQ_NEXT, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, ALU_PASSA, SH_PASS, 1'b0},
    {SEQ_NEXT, 4'd0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 2'd1, ALU_SUB,   SH_PASS, 1'b0},
    {SEQ_BRZ,  4'd6, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, ALU_PASSA, SH_PASS, 1'b0},
    {SEQ_NEXT, 4'd0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 2'd0, ALU_ADD,   SH_PASS, 1'b0},
    {SEQ_NEXT, 4'd0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, ALU_DEC,   SH_PASS, 1'b0},
    {SEQ_JUMP, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, ALU_PASSA, SH_PASS, 1'b0},
    {SEQ_HALT, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, ALU_PASSA, SH_PASS, 1'b1},
    22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0
  };

  // Words beyond the 16-entry default image read as all-zero (seq=next).
  function automatic logic [UINST_W-1:0] default_uinst(input int idx);
    logic [3:0] a;
    a = idx[3:0];
    default_uinst = '0;
    if (idx >= 0 && idx < 16) default_uinst = DEFAULT_PROG[a];
  endfunction

endpackage

// File: rtl/gdp_ucode_store.sv
// Control store with combinational read. Constant ROM by default; with
// GDP_USEQ_UCODE_LOAD_EN it becomes a RAM reloaded with the default image on reset.
module gdp_ucode_store
  import gdp_pkg::*;
#(
  parameter int UPC_W = 4
) (
`ifdef GDP_USEQ_UCODE_LOAD_EN
  input  logic               clock,
  input  logic               restart_n,
  input  logic               wr_en,
  input  logic [UPC_W-1:0]   wr_addr,
  input  logic [UINST_W-1:0] wr_data,
`endif
  input  logic [UPC_W-1:0]   rd_addr,
  output logic [UINST_W-1:0] rd_data
);

  localparam int DEPTH = 1 << UPC_W;

`ifdef GDP_USEQ_UCODE_LOAD_EN
  logic [UINST_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (!restart_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= default_uinst(i);
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];
`else
  assign rd_data = default_uinst(int'(rd_addr));
`endif

endmodule

// File: rtl/gdp_useq.sv
// Microprogrammed sequencer for the GDP datapath: IDLE/RUN/DONE FSM, upc and
// saturating run-cycle counter. GDP_USEQ_UCODE_LOAD_EN adds control-store write ports.
module gdp_useq
  import gdp_pkg::*;
#(
  parameter int UPC_W = 4,
  parameter int CYC_W = 10
) (
  input  logic               clock,
  input  logic               restart_n,
  input  logic               start,
  input  logic               abort,
  input  logic               n_is_0,
`ifdef GDP_USEQ_UCODE_LOAD_EN
  input  logic               ucode_we,
  input  logic [UPC_W-1:0]   ucode_addr,
  input  logic [UINST_W-1:0] ucode_data,
`endif
  output logic               ie,
  output logic               we,
  output logic               rae,
  output logic               rbe,
  output logic               oe,
  output logic [1:0]         wa,
  output logic [1:0]         raa,
  output logic [1:0]         rba,
  output logic [2:0]         alu,
  output logic [1:0]         sh,
  output logic               busy,
  output logic               done,
  output logic [CYC_W-1:0]   cycles,
  output logic [1:0]         dbg_state,
  output logic [UPC_W-1:0]   dbg_upc
);

  logic [1:0]         r_state;
  logic [UPC_W-1:0]   r_upc;
  logic [CYC_W-1:0]   r_cycles;
  logic [UINST_W-1:0] w_uinst;
  logic [1:0]         w_seq;
  logic [UPC_W-1:0]   w_target;
  logic [UPC_W-1:0]   w_upc_inc;

  gdp_ucode_store #(.UPC_W(UPC_W)) u_store (
`ifdef GDP_USEQ_UCODE_LOAD_EN
    .clock     (clock),
    .restart_n (restart_n),
    .wr_en     (ucode_we && (r_state == ST_IDLE)),
    .wr_addr   (ucode_addr),
    .wr_data   (ucode_data),
`endif
    .rd_addr   (r_upc),
    .rd_data   (w_uinst)
  );

  assign w_seq     = w_uinst[F_SEQ_HI:F_SEQ_LO];
  assign w_target  = UPC_W'(w_uinst[F_TGT_HI:F_TGT_LO]);
  assign w_upc_inc = r_upc + UPC_W'(1);

  // Handshake: start is a level request; busy covers the RUN phase, done rises
  // after halt and stays high until start is dropped, then the FSM returns to IDLE.
  always_ff @(posedge clock) begin
    if (!restart_n) begin
      r_state  <= ST_IDLE;
      r_upc    <= '0;
      r_cycles <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state  <= ST_RUN;
            r_upc    <= '0;
            r_cycles <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            if (r_cycles != '1) r_cycles <= r_cycles + CYC_W'(1);
            case (w_seq)
              SEQ_NEXT: r_upc <= w_upc_inc;
              SEQ_JUMP: r_upc <= w_target;
              SEQ_BRZ:  r_upc <= n_is_0 ? w_target : w_upc_inc;
              default:  r_state <= ST_DONE;
            endcase
          end
        end
        ST_DONE: begin
          if (abort || !start) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // DONE keeps the read path and oe alive so the result stays visible; only we is masked.
  always_comb begin
    ie  = 1'b0;
    we  = 1'b0;
    wa  = '0;
    rae = 1'b0;
    raa = '0;
    rbe = 1'b0;
    rba = '0;
    alu = '0;
    sh  = '0;
    oe  = 1'b0;
    if (r_state == ST_RUN || r_state == ST_DONE) begin
      ie  = w_uinst[F_IE];
      we  = (r_state == ST_RUN) && w_uinst[F_WE];
      wa  = w_uinst[F_WA_HI:F_WA_LO];
      rae = w_uinst[F_RAE];
      raa = w_uinst[F_RAA_HI:F_RAA_LO];
      rbe = w_uinst[F_RBE];
      rba = w_uinst[F_RBA_HI:F_RBA_LO];
      alu = w_uinst[F_ALU_HI:F_ALU_LO];
      sh  = w_uinst[F_SH_HI:F_SH_LO];
      oe  = w_uinst[F_OE];
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign cycles    = r_cycles;
  assign dbg_state = r_state;
  assign dbg_upc   = r_upc;

endmodule

// File: tb/tb_gdp_useq.sv
// Bench for gdp_useq: small 4x8-bit datapath environment, table-driven jobs,
// random jobs against a summation reference model, abort/restart corner cases.
module tb_gdp_useq;

  localparam int UPC_W = 4;
  localparam int CYC_W = 10;

  logic clock = 1'b0;
  logic restart_n, start, abort, n_is_0;
  logic ie, we, rae, rbe, oe, busy, done;
  logic [1:0] wa, raa, rba, sh, dbg_state;
  logic [2:0] alu;
  logic [CYC_W-1:0] cycles;
  logic [UPC_W-1:0] dbg_upc;
`ifdef GDP_USEQ_UCODE_LOAD_EN
  logic ucode_we;
  logic [UPC_W-1:0] ucode_addr;
  logic [21:0] ucode_data;
`endif

  logic [7:0] din, dp_a, dp_b, dp_alu, dp_res, dp_out;
  logic [7:0] dp_r [4];

  int n_checks = 0;
  int n_fail = 0;
  logic [CYC_W-1:0] exp_q[$];

  gdp_useq #(.UPC_W(UPC_W), .CYC_W(CYC_W)) dut (
    .clock(clock), .restart_n(restart_n), .start(start), .abort(abort), .n_is_0(n_is_0),
`ifdef GDP_USEQ_UCODE_LOAD_EN
    .ucode_we(ucode_we), .ucode_addr(ucode_addr), .ucode_data(ucode_data),
`endif
    .ie(ie), .we(we), .rae(rae), .rbe(rbe), .oe(oe), .wa(wa), .raa(raa), .rba(rba),
    .alu(alu), .sh(sh), .busy(busy), .done(done), .cycles(cycles),
    .dbg_state(dbg_state), .dbg_upc(dbg_upc)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  // datapath environment
  always_comb begin
    dp_a = rae ? dp_r[raa] : 8'd0;
    dp_b = rbe ? dp_r[rba] : 8'd0;
    case (alu)
      3'b000: dp_alu = dp_a;
      3'b001: dp_alu = dp_a & dp_b;
      3'b010: dp_alu = dp_a | dp_b;
      3'b011: dp_alu = ~dp_a;
      3'b100: dp_alu = dp_a + dp_b;
      3'b101: dp_alu = dp_a - dp_b;
      3'b110: dp_alu = dp_a + 8'd1;
      default: dp_alu = dp_a - 8'd1;
    endcase
    case (sh)
      2'b00: dp_res = dp_alu;
      2'b01: dp_res = {dp_alu[6:0], 1'b0};
      2'b10: dp_res = {1'b0, dp_alu[7:1]};
      default: dp_res = {dp_alu[0], dp_alu[7:1]};
    endcase
    n_is_0 = (dp_res == 8'd0);
    dp_out = oe ? dp_res : 8'd0;
  end

  always @(posedge clock) begin
    if (we) dp_r[wa] <= ie ? din : dp_res;
  end

  // reference model of the default summation program
  function automatic int ref_len(input int n);
    return 4 * n + 4;
  endfunction

  function automatic logic [CYC_W-1:0] ref_cyc(input int len);
    int sat;
    sat = (1 << CYC_W) - 1;
    return CYC_W'((len > sat) ? sat : len);
  endfunction

  function automatic logic [7:0] ref_sum(input int n);
    return 8'((n * (n + 1) / 2) % 256);
  endfunction

  // driver / checker tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ctrl_zero(input string name);
    check(name, {14'd0, ie, we, wa, rae, raa, rbe, rba, alu, sh, oe}, 32'd0);
  endtask

  task automatic run_job(input string name, input logic [7:0] n, input int exp_len,
                         input logic [7:0] exp_res, input logic [1:0] exp_raa,
                         input bit chk_trace);
    int busy_cnt;
    int guard;
    int trace_q[$];
    int exp_trace[$];
    bit trace_ok;
    exp_q.push_back(ref_cyc(exp_len));
    @(negedge clock);
    din = n;
    start = 1'b1;
    @(negedge clock);
    check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
    busy_cnt = 0;
    guard = 0;
    while (busy && guard < 2000) begin
      busy_cnt++;
      trace_q.push_back(int'(dbg_upc));
      guard++;
      @(negedge clock);
    end
    check({name, "_run_len"}, busy_cnt, exp_len);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_cycles"}, {22'd0, cycles}, {22'd0, exp_q.pop_front()});
    check({name, "_we_off"}, {31'd0, we}, 32'd0);
    check({name, "_oe"}, {31'd0, oe}, 32'd1);
    check({name, "_raa"}, {30'd0, raa}, {30'd0, exp_raa});
    check({name, "_result"}, {24'd0, dp_out}, {24'd0, exp_res});
    if (chk_trace) begin
      exp_trace.push_back(0);
      exp_trace.push_back(1);
      for (int k = 0; k < int'(n); k++) begin
        exp_trace.push_back(2);
        exp_trace.push_back(3);
        exp_trace.push_back(4);
        exp_trace.push_back(5);
      end
      exp_trace.push_back(2);
      exp_trace.push_back(6);
      trace_ok = (trace_q.size() == exp_trace.size());
      for (int k = 0; k < trace_q.size() && trace_ok; k++)
        if (trace_q[k] != exp_trace[k]) trace_ok = 1'b0;
      check({name, "_upc_trace"}, {31'd0, trace_ok}, 32'd1);
    end
    start = 1'b0;
    @(negedge clock);
    check({name, "_done_drop"}, {30'd0, busy, done}, 32'd0);
    check_ctrl_zero({name, "_idle_ctrl"});
  endtask

`ifdef GDP_USEQ_UCODE_LOAD_EN
  task automatic write_word(input logic [UPC_W-1:0] addr, input logic [21:0] data);
    @(negedge clock);
    ucode_we = 1'b1;
    ucode_addr = addr;
    ucode_data = data;
    @(negedge clock);
    ucode_we = 1'b0;
  endtask
`endif

  typedef struct {
    logic [7:0] n;
    int         exp_len;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int guard;
    bit stayed_idle;
    logic [7:0] rn;

    vecs[0] = '{n: 8'd5,   exp_len: 24,   exp_res: 8'd15};
    vecs[1] = '{n: 8'd0,   exp_len: 4,    exp_res: 8'd0};
    vecs[2] = '{n: 8'd1,   exp_len: 8,    exp_res: 8'd1};
    vecs[3] = '{n: 8'd3,   exp_len: 16,   exp_res: 8'd6};
    vecs[4] = '{n: 8'd255, exp_len: 1024, exp_res: 8'd128};

    for (int i = 0; i < 4; i++) dp_r[i] = 8'd0;
    restart_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    din = 8'd0;
`ifdef GDP_USEQ_UCODE_LOAD_EN
    ucode_we = 1'b0;
    ucode_addr = '0;
    ucode_data = '0;
`endif
    repeat (2) @(negedge clock);
    restart_n = 1'b1;
    @(negedge clock);

    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("reset_cycles", {22'd0, cycles}, 32'd0);
    check("reset_upc", {28'd0, dbg_upc}, 32'd0);
    check_ctrl_zero("reset_ctrl");

    // table-driven jobs
    for (int i = 0; i < 5; i++)
      run_job($sformatf("vec%0d", i), vecs[i].n, vecs[i].exp_len, vecs[i].exp_res, 2'd1, 1'b1);

    // random jobs against the model
    for (int i = 0; i < 6; i++) begin
      rn = 8'($urandom_range(0, 40));
      run_job($sformatf("rand%0d_n%0d", i, rn), rn, ref_len(int'(rn)), ref_sum(int'(rn)),
              2'd1, 1'b1);
    end

    // abort when cycles reads 7, then abort+start together in IDLE
    @(negedge clock);
    din = 8'd5;
    start = 1'b1;
    guard = 0;
    while (!(busy && cycles == 7) && guard < 100) begin
      guard++;
      @(negedge clock);
    end
    check("abort_reach7", {22'd0, cycles}, 32'd7);
    abort = 1'b1;
    @(negedge clock);
    check("abort_idle", {30'd0, busy, done}, 32'd0);
    check("abort_cycles_hold", {22'd0, cycles}, 32'd7);
    check("abort_we", {31'd0, we}, 32'd0);
    stayed_idle = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (busy || done) stayed_idle = 1'b0;
    end
    check("abort_start_idle", {31'd0, stayed_idle}, 32'd1);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clock);

    // restart_n low while in DONE
    din = 8'd2;
    start = 1'b1;
    guard = 0;
    @(negedge clock);
    while (!done && guard < 100) begin
      guard++;
      @(negedge clock);
    end
    check("rst_done_reached", {31'd0, done}, 32'd1);
    restart_n = 1'b0;
    @(negedge clock);
    check("rst_done_clear", {30'd0, busy, done}, 32'd0);
    check("rst_cycles", {22'd0, cycles}, 32'd0);
    check("rst_upc", {28'd0, dbg_upc}, 32'd0);
    restart_n = 1'b1;
    start = 1'b0;
    @(negedge clock);

`ifdef GDP_USEQ_UCODE_LOAD_EN
    write_word(4'd0, 22'h00E000);
    write_word(4'd1, 22'h300C01);
    write_word(4'd2, 22'h000000);
    run_job("ld_prog", 8'd77, 2, 8'd77, 2'd2, 1'b0);
    // a write while RUN must not reach the store
    @(negedge clock);
    din = 8'd33;
    start = 1'b1;
    @(negedge clock);
    ucode_we = 1'b1;
    ucode_addr = 4'd1;
    ucode_data = 22'h000000;
    @(negedge clock);
    ucode_we = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin
      guard++;
      @(negedge clock);
    end
    check("ld_run_wr_done", {31'd0, done}, 32'd1);
    check("ld_run_wr_cycles", {22'd0, cycles}, 32'd2);
    start = 1'b0;
    @(negedge clock);
    run_job("ld_again", 8'd9, 2, 8'd9, 2'd2, 1'b0);
    restart_n = 1'b0;
    @(negedge clock);
    restart_n = 1'b1;
    @(negedge clock);
    run_job("ld_reload", 8'd3, 16, 8'd6, 2'd1, 1'b1);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
